eth_ch_arbiter: RTL and testbench

Two-channel payload scheduler in front of the 1G UDP framer inside `eth_1g_top`. It watches the fill levels of the channel-1 and channel-2 sample FIFOs, which are written from `wrclk`. When a FIFO holds a full burst, it grants that channel round-robin. It then streams one frame to the framer: a header word, then `BURST_WORDS` payload words read from the granted FIFO. Per-channel sequence counters are cleared by `TIME_CLR`.

---
 rtl/eth_arb_pkg.sv | 15 +
 rtl/eth_arb_rr.sv | 30 +++
 rtl/eth_ch_arbiter.sv | 172 +++++++++++++++++
 tb/tb_eth_ch_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_arb_pkg.sv
// Shared types and constants for the two-channel Ethernet payload arbiter.
// Holds the scheduler state enum, header marker and sequence counter width.
package eth_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        GAP
    } arb_state_t;

    localparam logic [7:0] HDR_MARKER = 8'hA5;
    localparam int         SEQ_W      = 16;

endpackage

// File: rtl/eth_arb_rr.sv
// Two-way round-robin grant with a registered last_grant.
// Ports: clk, rst (async high), elig[1:0] in; update in (latch the grant);
//        req out (any eligible), gnt out (0 = ch0, 1 = ch1).
module eth_arb_rr (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] elig,
    input  logic       update,
    output logic       req,
    output logic       gnt
);

    logic last_grant;

    // On a tie the channel not served last wins; otherwise the sole requester.
    always_comb begin
        req = |elig;
        gnt = (&elig) ? ~last_grant : elig[1];
    end

    // Resetting to ch1 lets ch0 win the very first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (update) begin
            last_grant <= gnt;
        end
    end

endmodule

// File: rtl/eth_ch_arbiter.sv
// Two-channel payload scheduler: grants a channel whose FIFO holds a full
// burst, sends a header word then BURST_WORDS payload words to the framer.
// Ports: clk_125, reset_all (async high), time_clr (clear seq counters);
//        ch0/ch1_lvl, ch0/ch1_q in, ch0/ch1_rd out (show-ahead FIFOs);
//        tx_ready in; tx_valid, tx_sop, tx_eop, tx_data, busy out.
// Option: ETH_ARB_TRAILER_EN appends an XOR-of-payload word carrying eop.
module eth_ch_arbiter
    import eth_arb_pkg::*;
#(
    parameter int BURST_WORDS = 256,
    parameter int LVL_W       = 12,
    parameter int GAP_CYCLES  = 4
) (
    input  logic             clk_125,
    input  logic             reset_all,
    input  logic             time_clr,
    input  logic [LVL_W-1:0] ch0_lvl,
    input  logic [LVL_W-1:0] ch1_lvl,
    input  logic [31:0]      ch0_q,
    input  logic [31:0]      ch1_q,
    output logic             ch0_rd,
    output logic             ch1_rd,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic             tx_sop,
    output logic             tx_eop,
    output logic [31:0]      tx_data,
    output logic             busy
);

    localparam int CNT_W = $clog2(BURST_WORDS + GAP_CYCLES + 2);
`ifdef ETH_ARB_TRAILER_EN
    localparam int EOP_IDX = BURST_WORDS;
`else
    localparam int EOP_IDX = BURST_WORDS - 1;
`endif
    localparam logic [CNT_W-1:0] CNT_EOP = CNT_W'(EOP_IDX);
    localparam logic [CNT_W-1:0] CNT_GAP = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [LVL_W:0]   LVL_MIN = (LVL_W + 1)'(BURST_WORDS);

    arb_state_t       state;
    arb_state_t       next_state;
    logic             grant;
    logic [CNT_W-1:0] cnt;
    logic [SEQ_W-1:0] seq0;
    logic [SEQ_W-1:0] seq1;
    logic [1:0]       elig;
    logic             req;
    logic             rr_gnt;
    logic             rr_update;
    logic             last_word;
    logic             pay_word;
    logic [31:0]      payload;
`ifdef ETH_ARB_TRAILER_EN
    logic [31:0]      csum;
`endif

    assign elig[0] = {1'b0, ch0_lvl} >= LVL_MIN;
    assign elig[1] = {1'b0, ch1_lvl} >= LVL_MIN;

    eth_arb_rr u_rr (
        .clk    (clk_125),
        .rst    (reset_all),
        .elig   (elig),
        .update (rr_update),
        .req    (req),
        .gnt    (rr_gnt)
    );

    assign busy = (state != IDLE);

    always_comb begin
        next_state = state;
        rr_update  = 1'b0;
        tx_valid   = 1'b0;
        tx_sop     = 1'b0;
        tx_eop     = 1'b0;
        tx_data    = '0;
        ch0_rd     = 1'b0;
        ch1_rd     = 1'b0;
        payload    = grant ? ch1_q : ch0_q;
        last_word  = (cnt == CNT_EOP);
`ifdef ETH_ARB_TRAILER_EN
        // The trailer slot sits one past the last payload word.
        pay_word   = (cnt != CNT_W'(BURST_WORDS));
`else
        pay_word   = 1'b1;
`endif
        unique case (state)
            IDLE: begin
                if (req) begin
                    rr_update  = 1'b1;
                    next_state = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_sop   = 1'b1;
                tx_data  = {HDR_MARKER, grant, 7'b0,
                            grant ? seq1 : seq0};
                if (tx_ready) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_eop   = last_word;
                if (pay_word) begin
                    tx_data = payload;
                    ch0_rd  = tx_ready & ~grant;
                    ch1_rd  = tx_ready & grant;
                end else begin
`ifdef ETH_ARB_TRAILER_EN
                    tx_data = csum;
`endif
                end
                if (tx_ready && last_word) begin
                    next_state = GAP;
                end
            end
            GAP: begin
                if (cnt == CNT_GAP) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_125 or posedge reset_all) begin
        if (reset_all) begin
            state <= IDLE;
            grant <= 1'b0;
            cnt   <= '0;
            seq0  <= '0;
            seq1  <= '0;
        end else begin
            state <= next_state;
            if (rr_update) begin
                grant <= rr_gnt;
            end
            case (state)
                HDR:     if (tx_ready) cnt <= '0;
                DATA:    if (tx_ready) cnt <= last_word ? '0 : cnt + CNT_ONE;
                GAP:     cnt <= (cnt == CNT_GAP) ? '0 : cnt + CNT_ONE;
                default: cnt <= '0;
            endcase
            // A clear wins over the header increment in the same cycle.
            if (time_clr) begin
                seq0 <= '0;
                seq1 <= '0;
            end else if (state == HDR && tx_ready) begin
                if (grant) seq1 <= seq1 + 1'b1;
                else       seq0 <= seq0 + 1'b1;
            end
        end
    end

`ifdef ETH_ARB_TRAILER_EN
    always_ff @(posedge clk_125 or posedge reset_all) begin
        if (reset_all) begin
            csum <= '0;
        end else if (state == HDR && tx_ready) begin
            csum <= '0;
        end else if (ch0_rd | ch1_rd) begin
            csum <= csum ^ payload;
        end
    end
`endif

endmodule

// File: tb/tb_eth_ch_arbiter.sv
// Scoreboard bench for eth_ch_arbiter: FIFO models feed the DUT, a frame
// model predicts the output stream, a negedge monitor pops and compares.
module tb_eth_ch_arbiter;

    localparam int BW  = 256;
    localparam int LW  = 12;
    localparam int GAP = 4;
`ifdef ETH_ARB_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif

    logic          clk_125 = 1'b0;
    logic          reset_all;
    logic          time_clr;
    logic [LW-1:0] ch0_lvl;
    logic [LW-1:0] ch1_lvl;
    logic [31:0]   ch0_q;
    logic [31:0]   ch1_q;
    logic          ch0_rd;
    logic          ch1_rd;
    logic          tx_ready;
    logic          tx_valid;
    logic          tx_sop;
    logic          tx_eop;
    logic [31:0]   tx_data;
    logic          busy;

    eth_ch_arbiter #(
        .BURST_WORDS (BW),
        .LVL_W       (LW),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk_125   (clk_125),
        .reset_all (reset_all),
        .time_clr  (time_clr),
        .ch0_lvl   (ch0_lvl),
        .ch1_lvl   (ch1_lvl),
        .ch0_q     (ch0_q),
        .ch1_q     (ch1_q),
        .ch0_rd    (ch0_rd),
        .ch1_rd    (ch1_rd),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_sop    (tx_sop),
        .tx_eop    (tx_eop),
        .tx_data   (tx_data),
        .busy      (busy)
    );

    always #4 clk_125 = ~clk_125;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic        pay;
        logic        ch;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] f0[$];
    logic [31:0] f1[$];
    logic [31:0] m0[$];
    logic [31:0] m1[$];
    logic [15:0] mseq[2];
    logic        mlast;

    int checks   = 0;
    int failures = 0;
    int rmode    = 0;
    bit mon_en   = 1'b0;
    int rd0_cnt  = 0;
    int valid_seen = 0;
    int idle_run = 0;
    bit have_eop = 1'b0;
    bit exact_gap = 1'b0;
    bit hold_v   = 1'b0;
    logic [31:0] hold_d;
    logic        hold_s;
    logic        hold_e;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void refresh();
        ch0_lvl = (f0.size() > 4095) ? 12'hFFF : LW'(f0.size());
        ch1_lvl = (f1.size() > 4095) ? 12'hFFF : LW'(f1.size());
        ch0_q   = (f0.size() > 0) ? f0[0] : 32'h0;
        ch1_q   = (f1.size() > 0) ? f1[0] : 32'h0;
    endfunction

    function automatic exp_t mk(logic [31:0] d, logic s, logic e,
                                logic p, logic c);
        exp_t x;
        x.data = d;
        x.sop  = s;
        x.eop  = e;
        x.pay  = p;
        x.ch   = c;
        return x;
    endfunction

    // Frame model: grant rule, header format and sequence numbers applied
    // to every full burst written but not yet scheduled.
    task automatic schedule();
        while (m0.size() >= BW || m1.size() >= BW) begin
            bit e0 = (m0.size() >= BW);
            bit e1 = (m1.size() >= BW);
            bit c;
            logic [31:0] x = 32'h0;
            logic [31:0] w;
            c = (e0 && e1) ? !mlast : !e0;
            mlast = c;
            exp_q.push_back(mk({8'hA5, c, 7'b0, mseq[c]}, 1'b1, 1'b0, 1'b0, c));
            mseq[c] = mseq[c] + 16'd1;
            for (int i = 0; i < BW; i++) begin
                w = c ? m1.pop_front() : m0.pop_front();
                x = x ^ w;
                exp_q.push_back(mk(w, 1'b0, (i == BW - 1) && !TRL, 1'b1, c));
            end
            if (TRL) exp_q.push_back(mk(x, 1'b0, 1'b1, 1'b0, c));
        end
    endtask

    task automatic fill(int ch, int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            if (ch == 0) begin
                f0.push_back(w);
                m0.push_back(w);
            end else begin
                f1.push_back(w);
                m1.push_back(w);
            end
        end
        refresh();
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk_125);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        f0.delete();
        f1.delete();
        m0.delete();
        m1.delete();
        mseq[0] = 16'd0;
        mseq[1] = 16'd0;
        mlast = 1'b1;
        refresh();
    endtask

    task automatic wait_drain(string name, int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d words_left required=0",
                     name, exp_q.size());
            exp_q.delete();
        end
        step(GAP + 4);
    endtask

    task automatic wait_left(string name, int thr);
        int n = 0;
        while (exp_q.size() >= thr && n < 3000) begin
            step(1);
            n++;
        end
        chk({name, "_reached"}, exp_q.size() < thr, 1);
    endtask

    task automatic wait_sop(string name);
        int n = 0;
        while (!tx_sop && n < 50) begin
            step(1);
            n++;
        end
        chk({name, "_sop_seen"}, tx_sop, 1);
    endtask

    always @(posedge clk_125) begin
        #1;
        refresh();
        case (rmode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = !tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk_125) begin : mon
        exp_t e;
        bit hs;
        bit x0;
        bit x1;
        if (mon_en) begin
            hs = tx_valid && tx_ready;
            x0 = 1'b0;
            x1 = 1'b0;
            if (ch0_rd) rd0_cnt++;
            if (tx_valid) begin
                valid_seen++;
                chk("busy_when_valid", busy, 1);
            end
            if (hold_v) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, hold_d);
                chk("hold_sop", tx_sop, hold_s);
                chk("hold_eop", tx_eop, hold_e);
            end
            hold_v = tx_valid && !tx_ready;
            hold_d = tx_data;
            hold_s = tx_sop;
            hold_e = tx_eop;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%h required=none",
                             tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", tx_data, e.data);
                    chk("word_sop", tx_sop, e.sop);
                    chk("word_eop", tx_eop, e.eop);
                    x0 = e.pay && !e.ch;
                    x1 = e.pay && e.ch;
                end
                if (tx_sop && have_eop) begin
                    if (exact_gap) chk("gap_len", idle_run, GAP + 1);
                    else chk("gap_min", idle_run >= GAP + 1, 1);
                    have_eop = 1'b0;
                end
                if (tx_eop) begin
                    have_eop = 1'b1;
                    idle_run = 0;
                end
            end else if (!tx_valid) begin
                idle_run++;
            end
            chk("ch0_rd", ch0_rd, x0);
            chk("ch1_rd", ch1_rd, x1);
            if (ch0_rd && f0.size() > 0) void'(f0.pop_front());
            if (ch1_rd && f1.size() > 0) void'(f1.pop_front());
        end
    end

    initial begin
        #600000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        reset_all = 1'b1;
        time_clr  = 1'b0;
        tx_ready  = 1'b0;
        model_reset();
        step(2);
        chk("rst_valid", tx_valid, 0);
        chk("rst_sop", tx_sop, 0);
        chk("rst_eop", tx_eop, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_rd", {ch0_rd, ch1_rd}, 0);
        chk("rst_busy", busy, 0);
        reset_all = 1'b0;
        mon_en = 1'b1;
        step(2);

        // Single channel, ready high; second frame carries seq 1.
        rmode = 0;
        rd0_cnt = 0;
        fill(0, BW);
        schedule();
        wait_drain("single", 2000);
        chk("single_rd_cycles", rd0_cnt, BW);
        fill(0, BW);
        schedule();
        wait_drain("single2", 2000);

        // Both channels with two bursts each; exact gap between frames.
        have_eop = 1'b0;
        exact_gap = 1'b1;
        fill(0, 2 * BW);
        fill(1, 2 * BW);
        schedule();
        wait_drain("both", 4000);
        exact_gap = 1'b0;

        // Backpressure: toggling, then random ready.
        rmode = 1;
        fill(0, BW);
        fill(1, BW);
        schedule();
        wait_drain("toggle", 4000);
        rmode = 2;
        for (int r = 0; r < 4; r++) begin
            fill(0, BW * $urandom_range(0, 2));
            fill(1, BW * $urandom_range(0, 2));
            schedule();
            wait_drain("random", 6000);
        end

        // Eligibility boundary.
        rmode = 0;
        fill(0, BW - 1);
        schedule();
        v0 = valid_seen;
        step(100);
        chk("no_frame_255", valid_seen - v0, 0);
        fill(0, 1);
        schedule();
        chk("no_early_hdr", tx_valid, 0);
        step(1);
        chk("hdr_latency", tx_sop, 1);
        wait_drain("boundary", 2000);

        // time_clr in the middle of DATA.
        fill(0, BW);
        schedule();
        wait_left("clr_mid", BW / 2);
        time_clr = 1'b1;
        step(1);
        time_clr = 1'b0;
        mseq[0] = 16'd0;
        mseq[1] = 16'd0;
        wait_drain("clr_mid", 2000);
        fill(0, BW);
        fill(1, BW);
        schedule();
        wait_drain("clr_after", 4000);

        // time_clr on the header handshake cycle.
        fill(0, BW);
        schedule();
        wait_sop("clr_hdr");
        time_clr = 1'b1;
        step(1);
        time_clr = 1'b0;
        mseq[0] = 16'd0;
        mseq[1] = 16'd0;
        wait_drain("clr_hdr", 2000);
        fill(0, BW);
        schedule();
        wait_drain("clr_hdr_next", 2000);

        // Reset in the middle of a frame.
        fill(1, BW);
        schedule();
        wait_left("rst_mid", BW / 2);
        mon_en = 1'b0;
        reset_all = 1'b1;
        #1;
        chk("midrst_valid", tx_valid, 0);
        chk("midrst_sop_eop", {tx_sop, tx_eop}, 0);
        chk("midrst_data", tx_data, 0);
        chk("midrst_rd", {ch0_rd, ch1_rd}, 0);
        chk("midrst_busy", busy, 0);
        model_reset();
        hold_v = 1'b0;
        have_eop = 1'b0;
        step(2);
        reset_all = 1'b0;
        mon_en = 1'b1;
        step(1);
        fill(0, BW);
        schedule();
        wait_drain("after_rst", 2000);
        step(2);
        chk("final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
